// File: rtl/theremin_timer_pkg.sv
// Shared definitions for the theremin multi-channel interval timer.
// Holds the per-channel register offsets, the CONTROL and STATUS bit
// positions, and a helper that packs a two-flag register into a bus word.
// Imported by theremin_timer_channel and theremin_multi_timer.
package theremin_timer_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // Two flag bits placed in bits 1:0 of a 32-bit read word, all other bits zero.
  function automatic logic [31:0] pack_flags(input logic b1, input logic b0);
    return {30'b0, b1, b0};
  endfunction

endpackage

// File: rtl/theremin_timer_channel.sv
// One channel of the theremin multi-timer: down-counter, PERIOD, CONTROL
// (ITO, CONT), STATUS (TO, RUN) and the SNAP capture register.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   tick                  shared prescaler tick; the counter only moves on it
//   wr_status/control/
//   wr_period/wr_snap     decoded single-cycle write strobes for this channel
//   wdata                 write data truncated to the counter width
//   to, run, ito, cont    register flag state for readback
//   period, snap          PERIOD and SNAP register contents
//   irq                   TO & ITO
//   timeout_pulse         (THEREMIN_TIMER_PULSE_OUT_EN only) 1-clk pulse the
//                         cycle after a timeout reload
module theremin_timer_channel #(
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic [CNT_W-1:0] wdata,
  output logic             to,
  output logic             run,
  output logic             ito,
  output logic             cont,
  output logic             irq,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap
`ifdef THEREMIN_TIMER_PULSE_OUT_EN
  , output logic           timeout_pulse
`endif
);
  import theremin_timer_pkg::*;

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             to_q, to_d;
  logic             run_q, run_d;
  logic             ito_q, ito_d;
  logic             cont_q, cont_d;
  logic             reload_evt;

  // A zero count on an active tick is the timeout: reload and flag it.
  // Later assignments take priority: STOP beats START and the one-shot
  // clear, and a PERIOD write forces a reload of the new value and stops
  // the channel. A timeout beats a simultaneous TO clear so no event is lost.
  always_comb begin
    reload_evt = run_q && tick && (cnt_q == '0);
    cnt_d      = cnt_q;
    period_d   = period_q;
    snap_d     = snap_q;
    to_d       = to_q;
    run_d      = run_q;
    ito_d      = ito_q;
    cont_d     = cont_q;

    if (reload_evt)          cnt_d = period_q;
    else if (run_q && tick)  cnt_d = cnt_q - CNT_W'(1);

    if (wr_status)  to_d = 1'b0;
    if (reload_evt) to_d = 1'b1;

    if (reload_evt && !cont_q) run_d = 1'b0;
    if (wr_control) begin
      ito_d  = wdata[CTL_ITO];
      cont_d = wdata[CTL_CONT];
      if (wdata[CTL_START]) run_d = 1'b1;
      if (wdata[CTL_STOP])  run_d = 1'b0;
    end

    if (wr_period) begin
      period_d = wdata;
      cnt_d    = wdata;
      run_d    = 1'b0;
    end

    if (wr_snap) snap_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= RST_VAL;
      period_q <= RST_VAL;
      snap_q   <= '0;
      to_q     <= 1'b0;
      run_q    <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      to_q     <= to_d;
      run_q    <= run_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
    end
  end

`ifdef THEREMIN_TIMER_PULSE_OUT_EN
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (reset) pulse_q <= 1'b0;
    else       pulse_q <= reload_evt;
  end

  assign timeout_pulse = pulse_q;
`else
  // No pulse output in this build; the reload event stays internal.
`endif

  assign to     = to_q;
  assign run    = run_q;
  assign ito    = ito_q;
  assign cont   = cont_q;
  assign irq    = to_q & ito_q;
  assign period = period_q;
  assign snap   = snap_q;

endmodule

// File: rtl/theremin_multi_timer.sv
// Theremin multi-channel interval timer, Avalon-MM slave.
// NUM_CH independent channels share one free-running prescaler.
// Optional macro THEREMIN_TIMER_PULSE_OUT_EN adds the timeout_pulse port.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   address        word address {channel, reg[1:0]}
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       registered read data, valid one cycle after address
//   irq            OR of irq_vec
//   irq_vec        per-channel TO & ITO
//   timeout_pulse  (macro builds only) per-channel 1-clk reload pulse
module theremin_multi_timer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRESCALE   = 1,
  parameter int RST_PERIOD = 49999
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_CH)+1:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
`ifdef THEREMIN_TIMER_PULSE_OUT_EN
  , output logic [NUM_CH-1:0]         timeout_pulse
`endif
);
  import theremin_timer_pkg::*;

  localparam int ADDR_W = $clog2(NUM_CH) + 2;
  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   ps_q, ps_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              tick;
  logic              wr_en;
  logic [ADDR_W-1:0] ch_sel;
  logic [1:0]        reg_sel;

  logic [NUM_CH-1:0] to_w, run_w, ito_w, cont_w, irq_w;
  logic [CNT_W-1:0]  period_w [NUM_CH];
  logic [CNT_W-1:0]  snap_w   [NUM_CH];

  assign wr_en   = chipselect && !write_n;
  assign ch_sel  = address >> 2;
  assign reg_sel = address[1:0];
  assign tick    = (ps_q == '0);

  // Prescaler wraps at PRESCALE-1; with PRESCALE = 1 it sits at zero so every cycle ticks.
  always_comb begin
    if (ps_q == PS_W'(PRESCALE - 1)) ps_d = '0;
    else                              ps_d = ps_q + PS_W'(1);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic hit;
      assign hit = wr_en && (ch_sel == ADDR_W'(g));

      theremin_timer_channel #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (RST_PERIOD)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .wr_status  (hit && (reg_sel == REG_STATUS)),
        .wr_control (hit && (reg_sel == REG_CONTROL)),
        .wr_period  (hit && (reg_sel == REG_PERIOD)),
        .wr_snap    (hit && (reg_sel == REG_SNAP)),
        .wdata      (writedata[CNT_W-1:0]),
        .to         (to_w[g]),
        .run        (run_w[g]),
        .ito        (ito_w[g]),
        .cont       (cont_w[g]),
        .irq        (irq_w[g]),
        .period     (period_w[g]),
        .snap       (snap_w[g])
`ifdef THEREMIN_TIMER_PULSE_OUT_EN
        , .timeout_pulse (timeout_pulse[g])
`endif
      );
    end
  endgenerate

  // Read mux; channel numbers past NUM_CH match nothing and read zero.
  always_comb begin
    readdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == ADDR_W'(c)) begin
        case (reg_sel)
          REG_STATUS:  readdata_d = pack_flags(run_w[c], to_w[c]);
          REG_CONTROL: readdata_d = pack_flags(cont_w[c], ito_w[c]);
          REG_PERIOD:  readdata_d = 32'(period_w[c]);
          default:     readdata_d = 32'(snap_w[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q       <= '0;
      readdata_q <= '0;
    end else begin
      ps_q       <= ps_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_vec  = irq_w;
  assign irq      = |irq_w;

endmodule

// File: tb/tb_theremin_multi_timer.sv
// Randomised, model-checked bench for theremin_multi_timer with three
// channels (so channel 3 is an unmapped address), a 16-bit counter and a
// prescaler of 3.
module tb_theremin_multi_timer;
  import theremin_timer_pkg::*;

  localparam int NUM_CH     = 3;
  localparam int CNT_W      = 16;
  localparam int PRESCALE   = 3;
  localparam int RST_PERIOD = 49999;
  localparam int ADDR_W     = $clog2(NUM_CH) + 2;
  localparam int MASK       = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;
`ifdef THEREMIN_TIMER_PULSE_OUT_EN
  logic [NUM_CH-1:0] timeout_pulse;
`endif

  theremin_multi_timer #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .PRESCALE   (PRESCALE),
    .RST_PERIOD (RST_PERIOD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
`ifdef THEREMIN_TIMER_PULSE_OUT_EN
    , .timeout_pulse (timeout_pulse)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle_count = 0;

  // Reference model state, one entry per channel.
  int m_cnt  [NUM_CH];
  int m_per  [NUM_CH];
  int m_snap [NUM_CH];
  bit m_to   [NUM_CH];
  bit m_run  [NUM_CH];
  bit m_ito  [NUM_CH];
  bit m_cont [NUM_CH];
  bit m_pulse[NUM_CH];
  int m_ps;
  logic [31:0] m_rd;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle_count, got, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input int addr);
    int ch, rg;
    ch = addr >> 2;
    rg = addr & 3;
    if (ch >= NUM_CH) return 32'd0;
    case (rg)
      0:       return {30'd0, m_run[ch], m_to[ch]};
      1:       return {30'd0, m_cont[ch], m_ito[ch]};
      2:       return 32'(m_per[ch]);
      default: return 32'(m_snap[ch]);
    endcase
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic modelStep();
    bit tick, wr, evt;
    int ch, rg, old_cnt, data;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = RST_PERIOD; m_per[c] = RST_PERIOD; m_snap[c] = 0;
        m_to[c] = 0; m_run[c] = 0; m_ito[c] = 0; m_cont[c] = 0; m_pulse[c] = 0;
      end
      m_ps = 0;
      m_rd = 0;
      return;
    end
    m_rd = modelRead(int'(address));
    tick = (m_ps == 0);
    m_ps = (m_ps + 1) % PRESCALE;
    wr   = chipselect && !write_n;
    ch   = int'(address) >> 2;
    rg   = int'(address) & 3;
    data = int'(writedata & MASK);
    for (int c = 0; c < NUM_CH; c++) begin
      old_cnt = m_cnt[c];
      evt = m_run[c] && tick && (old_cnt == 0);
      m_pulse[c] = evt;
      if (evt) begin
        m_cnt[c] = m_per[c];
        m_to[c]  = 1;
        if (!m_cont[c]) m_run[c] = 0;
      end else if (m_run[c] && tick) begin
        m_cnt[c] = old_cnt - 1;
      end
      if (wr && ch == c) begin
        case (rg)
          0: if (!evt) m_to[c] = 0;
          1: begin
            m_ito[c]  = writedata[CTL_ITO];
            m_cont[c] = writedata[CTL_CONT];
            if (writedata[CTL_START]) m_run[c] = 1;
            if (writedata[CTL_STOP])  m_run[c] = 0;
          end
          2: begin
            m_per[c] = data;
            m_cnt[c] = data;
            m_run[c] = 0;
          end
          default: m_snap[c] = old_cnt;
        endcase
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] modelIrqVec();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_to[c] & m_ito[c];
    return v;
  endfunction

  // One clock: model follows the edge, outputs are checked 1 time unit later.
  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
    cycle_count++;
    checkOutput("readdata", readdata, m_rd);
    checkOutput("irq_vec", 32'(irq_vec), 32'(modelIrqVec()));
    checkOutput("irq", 32'(irq), 32'(|modelIrqVec()));
`ifdef THEREMIN_TIMER_PULSE_OUT_EN
    for (int c = 0; c < NUM_CH; c++)
      checkOutput("timeout_pulse", 32'(timeout_pulse[c]), 32'(m_pulse[c]));
`endif
  endtask

  task automatic applyStimulus(input int addr, input logic [31:0] data, input bit is_write);
    address    = ADDR_W'(addr);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = !is_write;
    stepCycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input int addr, output logic [31:0] value);
    applyStimulus(addr, 32'd0, 1'b0);
    value = readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic waitIrq(input int c, output int at_cycle);
    int budget;
    budget = 300;
    while (!irq_vec[c] && budget > 0) begin
      stepCycle();
      budget--;
    end
    if (budget == 0) checkOutput("wait_irq_bound", 32'(irq_vec[c]), 32'd1);
    at_cycle = cycle_count;
  endtask

  initial begin
    logic [31:0] v;
    int t1, t2, addr, rg;

    // Reset and read every register of every channel.
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_readdata", readdata, 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      readReg(c * 4 + 0, v); checkOutput("reset_status", v, 32'd0);
      readReg(c * 4 + 1, v); checkOutput("reset_control", v, 32'd0);
      readReg(c * 4 + 2, v); checkOutput("reset_period", v, 32'd49999);
      readReg(c * 4 + 3, v); checkOutput("reset_snap", v, 32'd0);
    end
    readReg(3 * 4 + 2, v); checkOutput("unmapped_read", v, 32'd0);

    // Channel 0 continuous, PERIOD 9: timeouts (9+1)*3 = 30 clk apart.
    applyStimulus(0 * 4 + 2, 32'd9, 1'b1);
    applyStimulus(0 * 4 + 1, 32'h7, 1'b1);
    waitIrq(0, t1);
    checkOutput("ch0_irq", 32'(irq), 32'd1);
    applyStimulus(0 * 4 + 0, 32'd0, 1'b1);
    checkOutput("ch0_to_clear", 32'(irq_vec[0]), 32'd0);
    waitIrq(0, t2);
    checkOutput("ch0_interval", 32'(t2 - t1), 32'd30);
    readReg(0 * 4 + 0, v);
    checkOutput("ch0_run_kept", 32'(v[ST_RUN]), 32'd1);
    applyStimulus(0 * 4 + 1, 32'h8, 1'b1);

    // Channel 1 one-shot, PERIOD 4 with upper junk bits that must be dropped.
    applyStimulus(1 * 4 + 2, 32'hABCD_0004, 1'b1);
    readReg(1 * 4 + 2, v); checkOutput("ch1_period_trunc", v, 32'd4);
    applyStimulus(1 * 4 + 1, 32'h5, 1'b1);
    waitIrq(1, t1);
    idle(40);
    readReg(1 * 4 + 0, v); checkOutput("ch1_oneshot_status", v, 32'h1);
    applyStimulus(1 * 4 + 3, 32'd0, 1'b1);
    readReg(1 * 4 + 3, v); checkOutput("ch1_reloaded", v, 32'd4);

    // Channel 2 continuous, PERIOD 2: snapshot must land in 0..2.
    applyStimulus(2 * 4 + 2, 32'd2, 1'b1);
    applyStimulus(2 * 4 + 1, 32'h7, 1'b1);
    idle(7);
    applyStimulus(2 * 4 + 3, 32'd0, 1'b1);
    readReg(2 * 4 + 3, v);
    checkOutput("ch2_snap_range", 32'(v <= 32'd2), 32'd1);

    // START|STOP together leaves RUN low; PERIOD write while running stops and loads.
    applyStimulus(2 * 4 + 1, 32'hC, 1'b1);
    readReg(2 * 4 + 0, v); checkOutput("start_stop_run", 32'(v[ST_RUN]), 32'd0);
    applyStimulus(2 * 4 + 1, 32'h7, 1'b1);
    idle(4);
    applyStimulus(2 * 4 + 2, 32'd5, 1'b1);
    readReg(2 * 4 + 0, v); checkOutput("period_wr_run", 32'(v[ST_RUN]), 32'd0);
    applyStimulus(2 * 4 + 3, 32'd0, 1'b1);
    readReg(2 * 4 + 3, v); checkOutput("period_wr_load", v, 32'd5);

    // Random bus traffic, every cycle checked against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 799) == 0);
      addr  = $urandom_range(0, 15);
      rg    = addr & 3;
      address = ADDR_W'(addr);
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        if (rg == 2)      writedata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
        else if (rg == 1) writedata = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
        else              writedata = $urandom;
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
        writedata  = $urandom;
      end
      stepCycle();
    end
    reset = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;

    // Reset with every channel running and irq high.
    for (int c = 0; c < NUM_CH; c++) begin
      applyStimulus(c * 4 + 2, 32'd3, 1'b1);
      applyStimulus(c * 4 + 1, 32'h7, 1'b1);
    end
    waitIrq(0, t1);
    checkOutput("pre_reset_irq", 32'(irq), 32'd1);
    reset = 1'b1;
    address = ADDR_W'(2);
    stepCycle();
    checkOutput("mid_reset_irq", 32'(irq), 32'd0);
    checkOutput("mid_reset_irq_vec", 32'(irq_vec), 32'd0);
    checkOutput("mid_reset_readdata", readdata, 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("post_reset_period", readdata, 32'd49999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
